// File: rtl/mc_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// mc_cpu_sequencer
// Multi-cycle control FSM for the RV32I-subset core. A single memory/IO port
// is shared by instruction fetch and data access; the FSM sequences
// IF/ID/EX/MEM/WB, stalls on MIO_ready and raises a sticky bus error when a
// memory access waits too long.
//
// Parameters
//   TIMEOUT_W   width of the bus-wait counter; 2**TIMEOUT_W-1 consecutive
//               not-ready cycles on one access end in the ERR state
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   OPcode/Fun3/Fun7    instruction fields IR[6:2], IR[14:12], IR[30]
//   Zero                ALU zero flag (branch resolution)
//   MIO_ready           memory/IO access completes this cycle
//   PCWrite, IRWrite    PC / IR load enables
//   IorD, MemRW,CPU_MIO memory address select, direction, request
//   RegWrite            register file write enable
//   ALUSrc_A/B, ImmSel  ALU operand and immediate selects
//   ALU_Control         ALU operation
//   MemtoReg, PCSource  write-back and PC source selects
//   state               current state (debug)
//   bus_err             sticky bus timeout flag
//   illegal             one-cycle pulse on an undecodable instruction
// ---------------------------------------------------------------------------
module mc_cpu_sequencer #(
  parameter int TIMEOUT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] OPcode,
  input  logic [2:0] Fun3,
  input  logic       Fun7,
  input  logic       Zero,
  input  logic       MIO_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRW,
  output logic       CPU_MIO,
  output logic       RegWrite,
  output logic [1:0] ALUSrc_A,
  output logic [1:0] ALUSrc_B,
  output logic [1:0] ImmSel,
  output logic [2:0] ALU_Control,
  output logic [1:0] MemtoReg,
  output logic       PCSource,
  output logic [3:0] state,
  output logic       bus_err,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_IF      = 4'h0,
    S_ID      = 4'h1,
    S_EXE_R   = 4'h2,
    S_EXE_I   = 4'h3,
    S_MEM_ADR = 4'h4,
    S_MEM_RD  = 4'h5,
    S_MEM_WR  = 4'h6,
    S_WB_ALU  = 4'h7,
    S_WB_LD   = 4'h8,
    S_BRANCH  = 4'h9,
    S_JAL     = 4'hA,
    S_ERR     = 4'hF
  } state_t;

  localparam logic [4:0] OP_R   = 5'b01100;
  localparam logic [4:0] OP_I   = 5'b00100;
  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_ST  = 5'b01000;
  localparam logic [4:0] OP_BR  = 5'b11000;
  localparam logic [4:0] OP_JAL = 5'b11011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // The counter holds the number of not-ready cycles already seen on the
  // current access, so a not-ready cycle arriving at this count is the
  // (2**TIMEOUT_W-1)-th consecutive one and ends the access in ERR.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(2**TIMEOUT_W - 2);

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic                 bus_err_q;
  logic                 wait_expired;

  // Fun3 -> ALU operation; SUB is only reachable for R-type with Fun7 set.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                            input logic       sub_sel);
    logic [2:0] op;
    case (f3)
      3'b000:  op = sub_sel ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b010:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  assign wait_expired = !MIO_ready && (wait_cnt_q == WAIT_LAST);

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IF;
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_q | (state_d == S_ERR);
    end
  end

  // ---- next state and output decode ----
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = '0;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    IorD        = 1'b0;
    MemRW       = 1'b0;
    CPU_MIO     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrc_A    = 2'b00;
    ALUSrc_B    = 2'b00;
    ImmSel      = 2'b00;
    ALU_Control = ALU_AND;
    MemtoReg    = 2'b00;
    PCSource    = 1'b0;
    illegal     = 1'b0;

    // Outputs are held at zero for as long as reset is asserted.
    if (rst_n) begin
      case (state_q)
        S_IF: begin
          CPU_MIO     = 1'b1;
          ALUSrc_B    = 2'b01;
          ALU_Control = ALU_ADD;
          if (MIO_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            state_d = S_ID;
          end else if (wait_expired) begin
            state_d = S_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end

        S_ID: begin
          // Branch target is computed speculatively into ALUOut.
          ALUSrc_A    = 2'b10;
          ALUSrc_B    = 2'b10;
          ImmSel      = 2'b10;
          ALU_Control = ALU_ADD;
          case (OPcode)
            OP_R:         state_d = S_EXE_R;
            OP_I:         state_d = S_EXE_I;
            OP_LD, OP_ST: state_d = S_MEM_ADR;
            OP_BR:        state_d = S_BRANCH;
            OP_JAL:       state_d = S_JAL;
            default: begin
              illegal = 1'b1;
              state_d = S_IF;
            end
          endcase
        end

        S_EXE_R: begin
          ALUSrc_A    = 2'b01;
          ALU_Control = alu_decode(Fun3, Fun7);
          state_d     = S_WB_ALU;
        end

        S_EXE_I: begin
          ALUSrc_A    = 2'b01;
          ALUSrc_B    = 2'b10;
          ALU_Control = alu_decode(Fun3, 1'b0);
          state_d     = S_WB_ALU;
        end

        S_WB_ALU: begin
          RegWrite = 1'b1;
          state_d  = S_IF;
        end

        S_MEM_ADR: begin
          ALUSrc_A    = 2'b01;
          ALUSrc_B    = 2'b10;
          ALU_Control = ALU_ADD;
          if (OPcode == OP_ST) begin
            ImmSel  = 2'b01;
            state_d = S_MEM_WR;
          end else begin
            state_d = S_MEM_RD;
          end
        end

        S_MEM_RD: begin
          CPU_MIO = 1'b1;
          IorD    = 1'b1;
          if (MIO_ready)         state_d = S_WB_LD;
          else if (wait_expired) state_d = S_ERR;
          else                   wait_cnt_d = wait_cnt_q + 1'b1;
        end

        S_WB_LD: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
          state_d  = S_IF;
        end

        S_MEM_WR: begin
          CPU_MIO = 1'b1;
          IorD    = 1'b1;
          MemRW   = 1'b1;
          if (MIO_ready)         state_d = S_IF;
          else if (wait_expired) state_d = S_ERR;
          else                   wait_cnt_d = wait_cnt_q + 1'b1;
        end

        S_BRANCH: begin
          ALUSrc_A    = 2'b01;
          ALU_Control = ALU_SUB;
          state_d     = S_IF;
          case (Fun3)
            3'b000: begin
              PCWrite  = Zero;
              PCSource = Zero;
            end
            3'b001: begin
              PCWrite  = !Zero;
              PCSource = !Zero;
            end
            default: illegal = 1'b1;
          endcase
        end

        S_JAL: begin
          // PC already holds oldPC+4 from IF, which is the link value.
          ALUSrc_A    = 2'b10;
          ALUSrc_B    = 2'b10;
          ImmSel      = 2'b11;
          ALU_Control = ALU_ADD;
          PCWrite     = 1'b1;
          RegWrite    = 1'b1;
          MemtoReg    = 2'b10;
          state_d     = S_IF;
        end

        S_ERR: state_d = S_ERR;

        default: state_d = S_IF;
      endcase
    end
  end

  assign state   = rst_n ? state_q : 4'h0;
  assign bus_err = rst_n & bus_err_q;

endmodule
